// File: rtl/apb_multi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_multi_timer
//  Description : NUM_CH down-counting timers (periodic / one-shot / PWM)
//                sharing one prescaler, behind a zero-wait-state APB slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_multi_timer #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic [5:0]        PADDR,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] PWMOUT,
    output logic [NUM_CH-1:0] TIMERINT,
    output logic              COMBINT
);

    logic [PRESC_W-1:0]            presc_q, presc_d, pcnt_q, pcnt_d;
    logic [NUM_CH-1:0]             intstat_q, intstat_d, intmask_q, intmask_d;
    logic [NUM_CH-1:0]             en_q, en_d, oneshot_q, oneshot_d;
    logic [NUM_CH-1:0]             pwmen_q, pwmen_d, pwm_q, pwm_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  load_q, load_d, value_q, value_d, cmp_q, cmp_d;

    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_hold;
    logic              w_glob, w_mapped, w_wr, w_tick;

    // Channel k decodes word addresses 4(k+1)..4(k+1)+3.
    // CTRL (offset 0) and VALUE (offset 2) writes pre-empt that cycle's tick.
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_hit
            assign w_hit[k]  = (PADDR[5:2] == 4'(k + 1));
            assign w_hold[k] = w_wr & w_hit[k] & ~PADDR[0];
        end
    endgenerate

    assign w_glob   = (PADDR[5:2] == 4'd0);
    assign w_mapped = w_glob ? (PADDR[1:0] != 2'd3) : (|w_hit);
    assign w_wr     = PSEL & PENABLE & PWRITE & w_mapped;
    assign w_tick   = (pcnt_q == presc_q);

    assign PREADY   = 1'b1;
    assign PSLVERR  = PSEL & PENABLE & ~w_mapped;
    assign PWMOUT   = pwm_q;
    assign TIMERINT = intstat_q & intmask_q;
    assign COMBINT  = |TIMERINT;

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            if (w_glob) begin
                case (PADDR[1:0])
                    2'd0:    PRDATA[PRESC_W-1:0] = presc_q;
                    2'd1:    PRDATA[NUM_CH-1:0]  = intstat_q;
                    2'd2:    PRDATA[NUM_CH-1:0]  = intmask_q;
                    default: PRDATA = '0;
                endcase
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_hit[k]) begin
                    case (PADDR[1:0])
                        2'd0:    PRDATA[2:0]       = {pwmen_q[k], oneshot_q[k], en_q[k]};
                        2'd1:    PRDATA[WIDTH-1:0] = load_q[k];
                        2'd2:    PRDATA[WIDTH-1:0] = value_q[k];
                        default: PRDATA[WIDTH-1:0] = cmp_q[k];
                    endcase
                end
            end
        end
    end

    always_comb begin
        presc_d   = presc_q;
        pcnt_d    = w_tick ? '0 : pcnt_q + 1'b1;
        intstat_d = intstat_q;
        intmask_d = intmask_q;
        en_d      = en_q;
        oneshot_d = oneshot_q;
        pwmen_d   = pwmen_q;
        load_d    = load_q;
        value_d   = value_q;
        cmp_d     = cmp_q;
        pwm_d     = '0;

        if (w_wr && w_glob) begin
            case (PADDR[1:0])
                2'd0: begin
                    presc_d = PWDATA[PRESC_W-1:0];
                    pcnt_d  = '0;
                end
                2'd1:    intstat_d = intstat_q & ~PWDATA[NUM_CH-1:0];
                2'd2:    intmask_d = PWDATA[NUM_CH-1:0];
                default: intmask_d = intmask_q;
            endcase
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (w_wr && w_hit[k]) begin
                case (PADDR[1:0])
                    2'd0: begin
                        en_d[k]      = PWDATA[0];
                        oneshot_d[k] = PWDATA[1];
                        pwmen_d[k]   = PWDATA[2];
                    end
                    2'd1:    load_d[k]  = PWDATA[WIDTH-1:0];
                    2'd2:    value_d[k] = PWDATA[WIDTH-1:0];
                    default: cmp_d[k]   = PWDATA[WIDTH-1:0];
                endcase
            end

            // Underflow set is applied after the W1C above so it wins;
            // reload reads load_q so a concurrent LOAD write lands next period.
            if (!w_hold[k] && w_tick && en_q[k]) begin
                if (|value_q[k]) begin
                    value_d[k] = value_q[k] - 1'b1;
                end else begin
                    intstat_d[k] = 1'b1;
                    if (oneshot_q[k]) en_d[k]    = 1'b0;
                    else              value_d[k] = load_q[k];
                end
            end

            pwm_d[k] = en_q[k] & pwmen_q[k] & (value_q[k] < cmp_q[k]);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            presc_q   <= '0;
            pcnt_q    <= '0;
            intstat_q <= '0;
            intmask_q <= '0;
            en_q      <= '0;
            oneshot_q <= '0;
            pwmen_q   <= '0;
            pwm_q     <= '0;
            load_q    <= '0;
            value_q   <= '0;
            cmp_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            intstat_q <= intstat_d;
            intmask_q <= intmask_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            pwmen_q   <= pwmen_d;
            pwm_q     <= pwm_d;
            load_q    <= load_d;
            value_q   <= value_d;
            cmp_q     <= cmp_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_multi_timer
//  Description : Self-checking bench: randomized APB traffic against an
//                integer-level timer model, plus directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_multi_timer;

    localparam int          NCH   = 4;
    localparam int          W     = 16;
    localparam int          PW    = 8;
    localparam int unsigned WMASK = (32'd1 << W) - 1;
    localparam int unsigned PMASK = (32'd1 << PW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            psel = 1'b0, pen = 1'b0, pwr = 1'b0;
    logic [5:0]      paddr = '0;
    logic [31:0]     pwdata = '0;
    logic [31:0]     prdata;
    logic            pready, pslverr, combint;
    logic [NCH-1:0]  pwmout, timerint;

    apb_multi_timer #(.NUM_CH(NCH), .WIDTH(W), .PRESC_W(PW)) dut (
        .PCLK(clk), .PRESET(rst), .PSEL(psel), .PADDR(paddr), .PENABLE(pen),
        .PWRITE(pwr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr), .PWMOUT(pwmout), .TIMERINT(timerint), .COMBINT(combint)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] rd_last;
    logic        slv_last;
    logic [NCH-1:0] ti_prev;

    // Reference model state, plain integers
    int unsigned    m_presc, m_pcnt;
    bit [NCH-1:0]   m_ist, m_imask, m_en, m_os, m_pe, m_pwm;
    int unsigned    m_load[NCH], m_val[NCH], m_cmp[NCH];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_err(int a);
        return (a == 3) || (a >= 4 && (a / 4 - 1) >= NCH);
    endfunction

    function automatic logic [31:0] model_rd(int a);
        int k;
        if (a == 0) return m_presc;
        if (a == 1) return 32'(m_ist);
        if (a == 2) return 32'(m_imask);
        if (is_err(a)) return 0;
        k = a / 4 - 1;
        case (a % 4)
            0:       return {29'd0, m_pe[k], m_os[k], m_en[k]};
            1:       return m_load[k];
            2:       return m_val[k];
            default: return m_cmp[k];
        endcase
    endfunction

    task automatic model_step();
        bit           tick, wr, touched;
        bit [NCH-1:0] fire;
        int           a, k;
        logic [31:0]  d;
        if (rst) begin
            m_presc = 0; m_pcnt = 0; m_ist = '0; m_imask = '0;
            m_en = '0; m_os = '0; m_pe = '0; m_pwm = '0;
            for (int i = 0; i < NCH; i++) begin
                m_load[i] = 0; m_val[i] = 0; m_cmp[i] = 0;
            end
            return;
        end
        a    = int'(paddr);
        d    = pwdata;
        tick = (m_pcnt == m_presc);
        wr   = psel && pen && pwr && !is_err(a);
        fire = '0;
        for (int i = 0; i < NCH; i++)
            m_pwm[i] = m_en[i] && m_pe[i] && (m_val[i] < m_cmp[i]);
        for (int i = 0; i < NCH; i++) begin
            touched = wr && a >= 4 && (a / 4 - 1) == i && (a % 2 == 0);
            if (tick && m_en[i] && !touched) begin
                if (m_val[i] > 0) m_val[i]--;
                else begin
                    fire[i] = 1'b1;
                    if (m_os[i]) m_en[i] = 1'b0;
                    else         m_val[i] = m_load[i];
                end
            end
        end
        m_pcnt = tick ? 0 : m_pcnt + 1;
        if (wr) begin
            if (a == 0) begin
                m_presc = d & PMASK;
                m_pcnt  = 0;
            end else if (a == 1) m_ist   = m_ist & ~d[NCH-1:0];
            else if (a == 2)     m_imask = d[NCH-1:0];
            else begin
                k = a / 4 - 1;
                case (a % 4)
                    0: begin m_en[k] = d[0]; m_os[k] = d[1]; m_pe[k] = d[2]; end
                    1: m_load[k] = d & WMASK;
                    2: m_val[k]  = d & WMASK;
                    default: m_cmp[k] = d & WMASK;
                endcase
            end
        end
        m_ist = m_ist | fire;
    endtask

    // One clock cycle: check combinational outputs, advance, check registered outputs.
    task automatic step();
        #3;
        chk("PRDATA", prdata, psel ? model_rd(int'(paddr)) : 32'd0);
        chk("PSLVERR", 32'(pslverr), 32'(psel && pen && is_err(int'(paddr))));
        rd_last  = prdata;
        slv_last = pslverr;
        ti_prev  = timerint;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        chk("PWMOUT", 32'(pwmout), 32'(m_pwm));
        chk("TIMERINT", 32'(timerint), 32'(m_ist & m_imask));
        chk("COMBINT", 32'(combint), 32'(|(m_ist & m_imask)));
        chk("PREADY", 32'(pready), 32'd1);
    endtask

    task automatic wr(int a, logic [31:0] d);
        psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 6'(a); pwdata = d;
        step();
        pen = 1'b1;
        step();
        psel = 1'b0; pen = 1'b0; pwr = 1'b0;
    endtask

    task automatic rd(int a, output logic [31:0] d);
        psel = 1'b1; pen = 1'b0; pwr = 1'b0; paddr = 6'(a);
        step();
        pen = 1'b1;
        step();
        d = rd_last;
        psel = 1'b0; pen = 1'b0;
    endtask

    task automatic wait_rise(int k, int maxc, output int t);
        t = -1;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (timerint[k] && !ti_prev[k]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_rise ch%0d: no TIMERINT edge within %0d cycles", k, maxc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          t0, t1, hi, a, r;

        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // Reset contents of every mapped and reserved word
        for (int i = 0; i < 20; i++) begin
            rd(i, d);
            chk("reset_read", d, 32'd0);
        end
        rd(3, d);
        chk("err_word3", 32'(slv_last), 32'd1);
        rd(20, d);
        chk("err_word20", 32'(slv_last), 32'd1);
        chk("read_word20", d, 32'd0);

        // Periodic channel 0, period 5
        wr(0, 0); wr(5, 4); wr(6, 4); wr(2, 1); wr(4, 1);
        wait_rise(0, 20, t0);
        wr(1, 1);
        chk("w1c_clears", 32'(timerint[0]), 32'd0);
        wait_rise(0, 20, t1);
        chk("period", 32'(t1 - t0), 32'd5);
        wr(4, 0); wr(1, 15);

        // One-shot channel 1 with prescaler 3: underflow 12 cycles after PRESCALE write
        wr(2, 2); wr(10, 2);
        wr(0, 3);
        t0 = cyc;
        wr(8, 3);
        wait_rise(1, 30, t1);
        chk("oneshot_delay", 32'(t1 - t0), 32'd12);
        rd(8, d);  chk("oneshot_ctrl", d, 32'd2);
        rd(10, d); chk("oneshot_value", d, 32'd0);

        // PWM channel 2: 3 high out of 10
        wr(0, 0); wr(13, 9); wr(15, 3); wr(12, 5);
        step(); step();
        hi = 0;
        for (int i = 0; i < 20; i++) begin step(); hi += int'(pwmout[2]); end
        chk("pwm_duty", 32'(hi), 32'd6);
        wr(15, 0); step(); step();
        hi = 0;
        for (int i = 0; i < 10; i++) begin step(); hi += int'(pwmout[2]); end
        chk("pwm_cmp0", 32'(hi), 32'd0);
        wr(15, 12); step(); step();
        hi = 0;
        for (int i = 0; i < 10; i++) begin step(); hi += int'(pwmout[2]); end
        chk("pwm_cmp_gt_load", 32'(hi), 32'd10);
        wr(12, 0);

        // W1C colliding with an underflow: the set wins
        wr(5, 20); wr(6, 20); wr(4, 1); wr(1, 15);
        wr(6, 1); wr(1, 1);
        rd(1, d); chk("w1c_vs_set", 32'(d[0]), 32'd1);
        wr(1, 1);
        rd(1, d); chk("w1c_plain", 32'(d[0]), 32'd0);

        // VALUE write landing on a tick edge wins
        wr(0, 3);
        step(); step();
        wr(6, 7);
        rd(6, d); chk("value_wr_vs_tick", d, 32'd7);

        // Writes truncate to WIDTH
        wr(7, 32'h0001_2345);
        rd(7, d); chk("truncate", d, 32'h0000_2345);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 23);
            if ($urandom_range(0, 9) == 0) d = $urandom;
            else                           d = $urandom_range(0, 12);
            if (a == 0 && $urandom_range(0, 19) != 0) d = $urandom_range(0, 3);
            if (r < 2) begin
                rst = 1'b1; step(); rst = 1'b0;
            end else if (r < 4) begin
                psel = 1'b1; pwr = 1'b1; paddr = 6'(a); pwdata = d; step();
                pen = 1'b1; rst = 1'b1; step();
                rst = 1'b0; psel = 1'b0; pen = 1'b0; pwr = 1'b0;
            end else if (r < 35) begin
                step();
            end else if (r < 70) begin
                wr(a, d);
            end else begin
                rd(a, d);
            end
        end

        // Reset in the middle of a transfer with channel 0 running
        wr(0, 0); wr(5, 5); wr(6, 5); wr(7, 3); wr(2, 15); wr(4, 5);
        for (int i = 0; i < 8; i++) step();
        psel = 1'b1; pwr = 1'b1; paddr = 6'd6; pwdata = 32'd9; pen = 1'b0;
        step();
        pen = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; psel = 1'b0; pen = 1'b0; pwr = 1'b0;
        chk("rst_pwmout", 32'(pwmout), 32'd0);
        chk("rst_timerint", 32'(timerint), 32'd0);
        for (int i = 0; i < 5; i++) step();
        rd(6, d); chk("rst_value_stopped", d, 32'd0);
        rd(4, d); chk("rst_ctrl", d, 32'd0);
        rd(0, d); chk("rst_prescale", d, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_multi_timer.md
# apb_multi_timer

Parametrised successor to the single-channel APB timer in the peripheral subsystem. It provides `NUM_CH` independent down-counting channels behind one APB slave port. The channels share a programmable prescaler, and each channel supports periodic, one-shot and PWM modes with a maskable per-channel interrupt. It occupies one 4 KB slot of the APB slave mux and is clocked by the subsystem `PCLK`.

## Interface
Parameters:
- `NUM_CH`, default 4: number of timer channels, 1..8.
- `WIDTH`, default 32: counter/LOAD/COMPARE width, 8..32. Unused upper read bits return 0.
- `PRESC_W`, default 16: prescaler register width.

Ports:
- `PCLK` in 1: the single clock.
- `PRESET` in 1: reset, synchronous, active-high.
- `PSEL` in 1: APB select.
- `PADDR` in 6: word address (byte address bits [7:2]).
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied to 1 (zero wait state).
- `PSLVERR` out 1: error on an unmapped word.
- `PWMOUT` out `NUM_CH`: per-channel PWM output.
- `TIMERINT` out `NUM_CH`: per-channel interrupt, equal to INTSTAT & INTMASK.
- `COMBINT` out 1: OR of `TIMERINT`.

## Operation
Register map (word address):
- 0x00 PRESCALE [`PRESC_W`-1:0], RW.
- 0x01 INTSTAT [`NUM_CH`-1:0]: read; write 1 to clear.
- 0x02 INTMASK [`NUM_CH`-1:0], RW.
- 0x03 reserved.
- Channel k occupies words 4(k+1)..4(k+1)+3:
  - CTRL, RW: bit0 EN, bit1 ONESHOT, bit2 PWMEN.
  - LOAD, RW.
  - VALUE, RW; a write sets the counter directly.
  - COMPARE, RW.

APB access rules:
- A write commits when `PSEL & PENABLE & PWRITE`.
- `PRDATA` is combinational from `PADDR` while `PSEL=1`, else 0.
- `PSLVERR=1` when `PSEL & PENABLE` and the word is reserved or belongs to a channel index ≥ `NUM_CH`. Writes to such words are ignored and reads return 0.

Prescaler:
- Free-running counter PCNT runs 0..PRESCALE.
- `tick` is asserted for one cycle when PCNT==PRESCALE; PCNT then returns to 0.
- A write to PRESCALE also clears PCNT.
- PRESCALE=0 gives a tick every cycle.

Channel k, on a cycle with `tick & EN`:
- If VALUE≠0: VALUE decrements by 1.
- If VALUE==0 (underflow):
  - INTSTAT[k] is set.
  - Periodic (ONESHOT=0): VALUE←LOAD.
  - One-shot: VALUE stays 0 and EN clears.
- With EN=0 the counter holds.

PWM:
- Registered `PWMOUT[k]` = EN & PWMEN & (VALUE < COMPARE). Otherwise 0.
- COMPARE=0 gives a constant 0; COMPARE>LOAD gives a constant 1 while running.

Counter width: VALUE wraps only via reload and never below 0. Writes truncate to `WIDTH` bits.

## Timing
- Reset values: all registers 0, PCNT 0, `PWMOUT`/`TIMERINT`/`COMBINT` = 0, `PRDATA` = 0, `PREADY` = 1, `PSLVERR` = 0.
- A write takes effect on the `PCLK` edge that ends the access phase and is readable in the next transfer.
- Underflow on edge N: INTSTAT[k] and `TIMERINT[k]` are high after edge N. `PWMOUT` reflects the new VALUE after edge N+1.
- Periodic interrupt period = (LOAD+1)·(PRESCALE+1) `PCLK` cycles.
- Simultaneous events:
  - A VALUE or CTRL write in the same cycle as a tick: the write wins and the tick is ignored for that channel.
  - An INTSTAT W1C in the same cycle as a new underflow of that channel: the set wins.
  - A LOAD write during an underflow: the reload uses the old LOAD.
- `PRESET` mid-count returns everything to reset values on the next edge, regardless of an APB transfer in progress.

## Test plan
- Reset, then read all words 0x00–0x13 → all 0. Word 0x03 → `PSLVERR=1`. With `NUM_CH`=4, word 0x14 → `PSLVERR=1`, read 0.
- Periodic: PRESCALE=0, LOAD=4, VALUE=4, INTMASK=1, CTRL0=1 → `TIMERINT[0]` rises every 5 cycles. W1C INTSTAT=1 clears it. `COMBINT` follows.
- One-shot with prescaler: PRESCALE=3, VALUE=2, CTRL1=0b011 → INTSTAT[1] set after 12 cycles, CTRL1 reads 0b010, VALUE stays 0.
- PWM: PRESCALE=0, LOAD=9, COMPARE=3, CTRL2=0b101 → `PWMOUT[2]` has a 3-high/7-low pattern with period 10. COMPARE=0 → constant 0.
- Collision: a W1C of INTSTAT[0] in the same cycle as channel 0 underflow → INTSTAT[0] remains 1. A VALUE write of 7 in a tick cycle → VALUE reads 7.
- `PRESET` asserted mid-count with ch0 running → the next cycle shows all outputs and registers at 0 and the counter stopped.
